// File: rtl/shot_pkg.sv
// Shared types and constants for the shot detector: FSM state encoding and sample-count width.
`default_nettype none

package shot_pkg;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TRACK    = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/shot_sample_ctr.sv
// Valid-gated, saturating, clearable sample counter used for shot length and cooldown.
`default_nettype none

module shot_sample_ctr
  import shot_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             clr,
  input  logic             load,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // clr wins over load; load starts a fresh count at one for the current sample
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (valid && load) begin
      count <= CNT_W'(1);
    end else if (valid && inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/shot_detector.sv
// Flick-magnitude shot detector with hysteresis, timeout and post-shot cooldown.
// Optional macro SHOT_MIN_LEN_EN discards shots shorter than MIN_SAMPLES.
`default_nettype none

module shot_detector
  import shot_pkg::*;
#(
  parameter logic [15:0] THRESH           = 16'd200,
  parameter logic [15:0] HYST             = 16'd50,
  parameter logic [7:0]  MAX_SAMPLES      = 8'd255,
  parameter logic [7:0]  COOLDOWN_SAMPLES = 8'd32,
  parameter logic [7:0]  MIN_SAMPLES      = 8'd3
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             flick_valid,
  input  logic [15:0]      flick,
  input  logic             arm,
  output logic             shot_valid,
  output logic [15:0]      shot_peak,
  output logic [CNT_W-1:0] shot_len,
  output logic             busy,
  output logic [1:0]       state_o
);

  // Release level clamps to zero when hysteresis swallows the threshold
  localparam logic [15:0] REL = (HYST >= THRESH) ? 16'd0 : (THRESH - HYST);

  state_t           state;
  state_t           state_nx;
  logic             start;
  logic             extend;
  logic             shot_end;
  logic             accept;
  logic             len_clr;
  logic             cd_clr;
  logic [CNT_W-1:0] len_r;
  logic [CNT_W-1:0] len_nx;
  logic [CNT_W-1:0] cd_cnt;
  logic [15:0]      peak_r;

  assign start    = (state == ST_IDLE) && arm && flick_valid && (flick >= THRESH);
  assign extend   = (state == ST_TRACK) && arm && flick_valid && (flick >= REL);
  assign shot_end = (state == ST_TRACK) && arm && flick_valid && (flick < REL);
  assign len_clr  = (state == ST_IDLE) && !start;
  assign cd_clr   = (state != ST_COOLDOWN);
  assign len_nx   = (len_r == CNT_MAX) ? len_r : (len_r + CNT_W'(1));

`ifdef SHOT_MIN_LEN_EN
  assign accept = (len_r >= MIN_SAMPLES);
`else
  // Minimum-length filter disabled: every hysteresis end is accepted
  assign accept = (len_r >= MIN_SAMPLES) | 1'b1;
`endif

  shot_sample_ctr u_len_ctr (
    .clk   (clk),
    .rst   (rst),
    .valid (flick_valid),
    .clr   (len_clr),
    .load  (start),
    .inc   (extend),
    .count (len_r)
  );

  shot_sample_ctr u_cd_ctr (
    .clk   (clk),
    .rst   (rst),
    .valid (flick_valid),
    .clr   (cd_clr),
    .load  (1'b0),
    .inc   (1'b1),
    .count (cd_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (!arm) begin
          state_nx = ST_IDLE;
        end else if (shot_end) begin
          state_nx = ST_COOLDOWN;
        end else if (extend && (len_nx >= MAX_SAMPLES)) begin
          state_nx = ST_COOLDOWN;
        end
      end
      ST_COOLDOWN: begin
        if (COOLDOWN_SAMPLES == 8'd0) begin
          state_nx = ST_IDLE;
        end else if (flick_valid &&
                     (({1'b0, cd_cnt} + 9'd1) >= {1'b0, COOLDOWN_SAMPLES})) begin
          state_nx = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      peak_r <= '0;
    end else if (start) begin
      peak_r <= flick;
    end else if (extend && (flick > peak_r)) begin
      peak_r <= flick;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shot_valid <= 1'b0;
      shot_peak  <= '0;
      shot_len   <= '0;
    end else begin
      shot_valid <= shot_end && accept;
      if (shot_end && accept) begin
        shot_peak <= peak_r;
        shot_len  <= len_r;
      end
    end
  end

  assign busy    = (state != ST_IDLE);
  assign state_o = state;

endmodule

`default_nettype wire

// File: tb/tb_shot_detector.sv
// Scoreboard bench for shot_detector: directed scenarios plus randomized samples vs a queue-based model.
`default_nettype none

module tb_shot_detector;

  localparam int THRESH = 200;
  localparam int REL    = 150;
  localparam int MAXS   = 255;
  localparam int CDS    = 32;
  localparam int MINS   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flick_valid = 1'b0;
  logic [15:0] flick = '0;
  logic        arm = 1'b0;
  logic        shot_valid;
  logic [15:0] shot_peak;
  logic [7:0]  shot_len;
  logic        busy;
  logic [1:0]  state_o;

  always #5 clk = ~clk;

  shot_detector dut (
    .clk         (clk),
    .rst         (rst),
    .flick_valid (flick_valid),
    .flick       (flick),
    .arm         (arm),
    .shot_valid  (shot_valid),
    .shot_peak   (shot_peak),
    .shot_len    (shot_len),
    .busy        (busy),
    .state_o     (state_o)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  // Reference model: 0 idle, 1 tracking, 2 cooling down
  int          m_state   = 0;
  int          m_cd_left = 0;
  int          m_shot[$];
  bit          m_valid   = 1'b0;
  int          m_peak    = 0;
  int          m_len     = 0;

  typedef struct {
    int cyc;
    int peak;
    int len;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int shot_max();
    int m = 0;
    foreach (m_shot[i]) if (m_shot[i] > m) m = m_shot[i];
    return m;
  endfunction

  task automatic model_step();
    bit   acc;
    exp_t e;
    m_valid = 1'b0;
    if (rst) begin
      m_state = 0; m_cd_left = 0; m_shot.delete();
      m_peak = 0; m_len = 0;
    end else begin
      case (m_state)
        0: if (arm && flick_valid && flick >= THRESH) begin
          m_shot.delete(); m_shot.push_back(int'(flick)); m_state = 1;
        end
        1: if (!arm) begin
          m_shot.delete(); m_state = 0;
        end else if (flick_valid) begin
          if (flick < REL) begin
`ifdef SHOT_MIN_LEN_EN
            acc = (m_shot.size() >= MINS);
`else
            acc = 1'b1;
`endif
            if (acc) begin
              m_valid = 1'b1; m_peak = shot_max(); m_len = m_shot.size();
              e.cyc = cyc; e.peak = m_peak; e.len = m_len;
              sb.push_back(e);
            end
            m_state = 2; m_cd_left = CDS;
          end else begin
            m_shot.push_back(int'(flick));
            if (m_shot.size() >= MAXS) begin
              m_state = 2; m_cd_left = CDS;
            end
          end
        end
        default: if (m_cd_left == 0) begin
          m_state = 0;
        end else if (flick_valid) begin
          m_cd_left--;
          if (m_cd_left == 0) m_state = 0;
        end
      endcase
    end
  endtask

  task automatic tick(input bit v, input int f, input bit a, input bit r);
    flick_valid = v; flick = f[15:0]; arm = a; rst = r;
    @(posedge clk);
    cyc++;
    model_step();
    mon_en = 1'b1;
    #1;
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 0, 1'b1, 1'b0);
  endtask

  // Monitor: every cycle state/outputs vs model; each pulse pops the scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      check("state_o", int'(state_o), m_state);
      check("busy", int'(busy), int'(m_state != 0));
      check("shot_valid", int'(shot_valid), int'(m_valid));
      check("shot_peak_hold", int'(shot_peak), m_peak);
      check("shot_len_hold", int'(shot_len), m_len);
      if (shot_valid) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_pulse", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_cycle", cyc, e.cyc);
          check("sb_peak", int'(shot_peak), e.peak);
          check("sb_len", int'(shot_len), e.len);
        end
      end
    end
  end

  initial begin
    int a1[5];
    int a2[4];
    bit a;
    int r;
    int f;

    // Reset
    tick(0, 0, 0, 1); tick(0, 0, 0, 1); tick(0, 0, 1, 0);
    check("rst_state", int'(state_o), 0);
    check("rst_peak", int'(shot_peak), 0);
    check("rst_len", int'(shot_len), 0);

    // Basic shot
    a1 = '{10, 250, 400, 300, 20};
    foreach (a1[i]) tick(1, a1[i], 1, 0);
    check("basic_pulse", int'(shot_valid), 1);
    check("basic_peak", int'(shot_peak), 400);
    check("basic_len", int'(shot_len), 3);
    check("basic_cooldown", int'(state_o), 2);
    flush(CDS);

    // Hysteresis extends track
    a2 = '{250, 160, 140, 100};
    for (int i = 0; i < 3; i++) tick(1, a2[i], 1, 0);
    check("hyst_peak", int'(shot_peak), 250);
    check("hyst_len", int'(shot_len), 2);
    tick(1, a2[3], 1, 0);

    // Cooldown: invalid samples do not count; 32nd valid ignored, 33rd triggers
    for (int i = 0; i < 3; i++) tick(0, 500, 1, 0);
    flush(30);
    tick(1, 500, 1, 0);
    check("cd_ignored", int'(state_o), 0);
    tick(1, 500, 1, 0);
    check("cd_retrigger", int'(state_o), 1);
    tick(1, 20, 1, 0);
    flush(CDS);

    // Timeout discards
    for (int i = 0; i < MAXS - 1; i++) tick(1, 300, 1, 0);
    check("to_still_track", int'(state_o), 1);
    tick(1, 300, 1, 0);
    check("to_cooldown", int'(state_o), 2);
    check("to_no_pulse", int'(shot_valid), 0);
    check("to_peak_held", int'(shot_peak), 500);
    check("to_len_held", int'(shot_len), 1);
    flush(CDS);

    // Arm drop aborts
    tick(1, 300, 1, 0); tick(1, 300, 1, 0);
    tick(1, 300, 0, 0);
    check("arm_abort", int'(state_o), 0);
    tick(1, 20, 1, 0);
    check("arm_no_cooldown", int'(state_o), 0);

    // Reset on the ending sample suppresses the pulse
    tick(1, 300, 1, 0); tick(1, 300, 1, 0);
    tick(1, 20, 1, 1);
    check("rst_no_pulse", int'(shot_valid), 0);
    check("rst_mid_peak", int'(shot_peak), 0);
    check("rst_mid_state", int'(state_o), 0);
    tick(0, 0, 1, 0);

    // Short shot
    tick(1, 300, 1, 0); tick(1, 300, 1, 0); tick(1, 20, 1, 0);
`ifdef SHOT_MIN_LEN_EN
    check("short_pulse", int'(shot_valid), 0);
    check("short_len", int'(shot_len), 0);
`else
    check("short_pulse", int'(shot_valid), 1);
    check("short_len", int'(shot_len), 2);
`endif
    check("short_cooldown", int'(state_o), 2);
    flush(CDS);

    // Randomized traffic
    a = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (a && $urandom_range(0, 59) == 0) a = 1'b0;
      else if (!a && $urandom_range(0, 3) == 0) a = 1'b1;
      r = $urandom_range(0, 7);
      case (r)
        0, 1, 2: f = $urandom_range(0, 149);
        3:       f = $urandom_range(150, 199);
        4: begin
          case ($urandom_range(0, 3))
            0: f = 149;
            1: f = 150;
            2: f = 199;
            default: f = 200;
          endcase
        end
        default: f = $urandom_range(200, 1000);
      endcase
      tick(($urandom_range(0, 3) != 0), f, a, ($urandom_range(0, 499) == 0));
    end

    flush(CDS + 2);
    check("sb_empty", sb.size(), 0);
    @(negedge clk);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shot_detector.md
SHOT_DETECTOR -- requirements
Module: shot_detector

Interface
REQ-001 SHALL have parameter THRESH, default 16'd200, trigger level on flick magnitude (unsigned).
REQ-002 SHALL have parameter HYST, default 16'd50, hysteresis; release level REL = THRESH-HYST (16-bit unsigned, computed at elaboration).
REQ-003 SHALL have parameter MAX_SAMPLES, default 8'd255, TRACK timeout in samples.
REQ-004 SHALL have parameter COOLDOWN_SAMPLES, default 8'd32, post-shot lockout in samples.
REQ-005 SHALL have parameter MIN_SAMPLES, default 8'd3, minimum shot length (used only with SHOT_MIN_LEN_EN).
REQ-006 SHALL have ports:
  clk          in   1   clock
  rst          in   1   reset, synchronous, active-high
  flick_valid  in   1   sample strobe, same cycle as flick
  flick        in   16  unsigned spike magnitude from high-pass filter stage
  arm          in   1   level enable; detection only while high
  shot_valid   out  1   one-cycle pulse, shot accepted
  shot_peak    out  16  max flick of last accepted shot
  shot_len     out  8   samples in last accepted shot
  busy         out  1   high when state != IDLE
  state_o      out  2   current FSM state (debug/LCD)

Function
REQ-007 SHALL implement FSM IDLE(0), TRACK(1), COOLDOWN(2); encoding 3 unused, SHALL go to IDLE.
REQ-008 All state changes, counters and comparisons SHALL advance only on cycles with flick_valid=1, except arm-drop and rst.
REQ-009 IDLE: arm=1, flick_valid=1, flick>=THRESH -> TRACK; peak_r<=flick, len_r<=1.
REQ-010 TRACK, valid sample with flick>=REL: peak_r<=max(peak_r,flick); len_r<=len_r+1, saturating at 255.
REQ-011 TRACK, valid sample with flick<REL: shot ends; sample not counted in len_r or peak_r; -> COOLDOWN.
REQ-012 On shot end, shot_valid SHALL pulse high exactly one cycle, registered (cycle after the ending sample); shot_peak<=peak_r, shot_len<=len_r same edge.
REQ-013 TRACK, len_r reaching MAX_SAMPLES: discard (no pulse, outputs unchanged) -> COOLDOWN.
REQ-014 TRACK, arm=0 any cycle: abort -> IDLE, no pulse, no cooldown.
REQ-015 COOLDOWN: count COOLDOWN_SAMPLES valid samples, then -> IDLE; arm ignored; COOLDOWN_SAMPLES=0 SHALL return to IDLE on next cycle.
REQ-016 HYST>=THRESH SHALL yield REL=0: shot ends only via timeout or arm-drop.
REQ-017 shot_peak/shot_len SHALL hold between accepted shots.
REQ-018 busy and state_o SHALL be combinational from the state register.

Reset
REQ-019 rst SHALL force state IDLE; peak_r, len_r, counters, shot_peak, shot_len to 0; shot_valid to 0.
REQ-020 rst mid-TRACK SHALL suppress any pending shot_valid pulse.

Configuration
REQ-021 Macro SHOT_MIN_LEN_EN defined: shot ending with len_r<MIN_SAMPLES SHALL be discarded (no pulse, outputs held) but still enter COOLDOWN.
REQ-022 Macro undefined: every REQ-011 end SHALL be accepted; MIN_SAMPLES unused.

Structure
REQ-023 Package shot_pkg SHALL hold state enum type, state encodings, and sample-count width constant (8).
REQ-024 One sub-module shot_sample_ctr (valid-gated, saturating, clearable 8-bit counter) SHALL be instantiated for len_r and cooldown counts.

Verification
REQ-025 arm=1, samples 10,250,400,300,20 -> one shot_valid, shot_peak=400, shot_len=3, then COOLDOWN.
REQ-026 Samples 250,160,140,100 (REL=150) -> 160 extends track, end at 140, shot_len=2, shot_peak=250.
REQ-027 Shot ends, new 500 sample within 32 valid samples -> ignored; 500 on 33rd valid sample after end -> TRACK.
REQ-028 300 held for 255 samples -> no pulse, COOLDOWN, shot_peak/shot_len unchanged.
REQ-029 arm drops mid-TRACK, or rst mid-TRACK -> IDLE, no pulse, (rst) outputs 0.
REQ-030 SHOT_MIN_LEN_EN defined, samples 300,300,20 -> no pulse; undefined -> pulse, shot_len=2.
